// File: rtl/ps2_kbd_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register map,
// STATUS bit positions, receiver FSM states and the frame parity rule.
package ps2_kbd_rx_pkg;

  localparam logic PS2_DATA_ADDR = 1'b0;
  localparam logic PS2_STAT_ADDR = 1'b1;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_PERR    = 2;
  localparam int STAT_FERR    = 3;
  localparam int STAT_OVF     = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  localparam int DATA_VALID_BIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  // A frame is good when the 8 data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scan codes; a pop on empty is ignored and
// a push on full only lands when a pop frees a slot in the same cycle.
module ps2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the raw lines, deframes 11-bit frames,
// buffers good bytes and exposes a polled DATA/STATUS register pair.
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              sel,
  input  logic              we,
  input  logic              addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

  logic clk_s1, clk_s2, clk_hist, data_s1, data_s2, fall;
  rx_state_t state, next_state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            timeout;
  logic shift_en, par_en, push_req, set_ferr, set_perr, set_ovf, clr_err, pop;
  logic perr, ferr, ovf;
  logic [7:0]  head;
  logic        fifo_empty, fifo_full;
  logic [AW:0] fifo_count;
  logic [DATA_W-1:0] status_word, data_word;
  logic unused_data_in;

  assign unused_data_in = ^data_in[DATA_W-1:1];

  // Synchroniser and history flops start at 1 so reset never fakes a falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_hist <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_hist <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall    = clk_hist && !clk_s2;
  assign timeout = (state != ST_IDLE) && (to_cnt == TO_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    push_req   = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    if (timeout) begin
      next_state = ST_IDLE;
      set_ferr   = 1'b1;
    end else if (fall) begin
      case (state)
        ST_IDLE: if (!data_s2) next_state = ST_DATA;
        ST_DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) next_state = ST_PARITY;
        end
        ST_PARITY: begin
          par_en     = 1'b1;
          next_state = ST_STOP;
        end
        ST_STOP: begin
          next_state = ST_IDLE;
          if (!data_s2)                           set_ferr = 1'b1;
          else if (!odd_parity_ok(shreg, par_bit)) set_perr = 1'b1;
          else                                     push_req = 1'b1;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // The timeout counter only runs while a frame is in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      if (state == ST_IDLE) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shreg   <= {data_s2, shreg[7:1]};
      if (par_en)   par_bit <= data_s2;
      if (fall || state == ST_IDLE) to_cnt <= '0;
      else if (to_cnt != TO_LIMIT)  to_cnt <= to_cnt + 1'b1;
    end
  end

  assign pop     = sel && !we && (addr == PS2_DATA_ADDR) && !fifo_empty;
  assign clr_err = sel && we && (addr == PS2_STAT_ADDR) && data_in[0];
  assign set_ovf = push_req && fifo_full && !pop;

  // A new error event outranks a clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      perr <= set_perr || (perr && !clr_err);
      ferr <= set_ferr || (ferr && !clr_err);
      ovf  <= set_ovf  || (ovf  && !clr_err);
    end
  end

  ps2_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .wdata (shreg),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[STAT_EMPTY] = fifo_empty;
    status_word[STAT_FULL]  = fifo_full;
    status_word[STAT_PERR]  = perr;
    status_word[STAT_FERR]  = ferr;
    status_word[STAT_OVF]   = ovf;
    status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    data_word = '0;
    if (!fifo_empty) begin
      data_word[DATA_VALID_BIT] = 1'b1;
      data_word[7:0]            = head;
    end
    if (!sel)                        data_out = '0;
    else if (addr == PS2_STAT_ADDR)  data_out = status_word;
    else                             data_out = data_word;
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: a vector table, hand-written corner cases
// and a randomised phase scored against a queue-based model of the receiver.
module tb_ps2_kbd_rx;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 300;
  localparam int HALF    = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ps2_clk = 1'b1;
  logic              ps2_data = 1'b1;
  logic              sel = 1'b0;
  logic              we = 1'b0;
  logic              addr = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;

  int asserts = 0;
  int failures = 0;

  ps2_kbd_rx #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .sel      (sel),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        par;
    logic        stop;
    logic [31:0] exp_stat;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs[6];

  logic [7:0] mq[$];
  logic m_perr, m_ferr, m_ovf;
  logic [31:0] v;
  logic [31:0] pop_val;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // When pop_on_stop is set, a DATA read is placed so its pop shares the clock
  // edge with the push triggered by the stop-bit falling edge.
  task automatic sendFrame(input logic [7:0] d, input logic p, input logic s,
                           input logic pop_on_stop, output logic [31:0] popped);
    popped = '0;
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(d[i]);
    sendBit(p);
    @(negedge clk);
    ps2_data = s;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_on_stop) begin
      repeat (2) @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = 1'b0;
      #1 popped = data_out;
      @(negedge clk);
      sel = 1'b0;
      repeat (HALF - 3) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic readReg(input logic a, output logic [31:0] val);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 val = data_out;
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic writeReg(input logic a, input logic [31:0] val);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; data_in = val;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; data_in = '0;
  endtask

  function automatic logic [31:0] modelStatus();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() == 0);
    s[1] = (mq.size() == DEPTH);
    s[2] = m_perr;
    s[3] = m_ferr;
    s[4] = m_ovf;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  task automatic modelFrame(input logic [7:0] d, input logic p, input logic s);
    if (!s)                                  m_ferr = 1'b1;
    else if ((($countones(d) + p) % 2) == 0) m_perr = 1'b1;
    else if (mq.size() == DEPTH)             m_ovf = 1'b1;
    else                                     mq.push_back(d);
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 32'h100, 32'h11C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 32'h005, 32'h000};
    vecs[2] = '{8'h55, 1'b1, 1'b0, 32'h009, 32'h000};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 32'h100, 32'h1FF};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 32'h100, 32'h100};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 32'h005, 32'h000};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    #1 checkOutput("idle_bus", data_out, 32'h0);
    readReg(1'b1, v); checkOutput("reset_status", v, 32'h001);
    readReg(1'b0, v); checkOutput("reset_data_empty", v, 32'h000);

    for (int i = 0; i < 6; i++) begin
      sendFrame(vecs[i].data, vecs[i].par, vecs[i].stop, 1'b0, pop_val);
      readReg(1'b1, v); checkOutput($sformatf("vec%0d_status", i), v, vecs[i].exp_stat);
      readReg(1'b0, v); checkOutput($sformatf("vec%0d_read", i), v, vecs[i].exp_read);
      writeReg(1'b1, 32'h1);
      readReg(1'b1, v); checkOutput($sformatf("vec%0d_cleared", i), v, 32'h001);
    end

    for (int i = 1; i <= 5; i++) sendFrame(8'(i), ~^(8'(i)), 1'b1, 1'b0, pop_val);
    writeReg(1'b0, 32'hFFFF_FFFF);
    readReg(1'b1, v); checkOutput("overflow_status", v, 32'h412);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = 1'b0;
    #1 checkOutput("b2b_read0", data_out, 32'h101);
    @(negedge clk);
    #1 checkOutput("b2b_read1", data_out, 32'h102);
    @(negedge clk);
    sel = 1'b0;
    readReg(1'b0, v); checkOutput("ovf_read2", v, 32'h103);
    readReg(1'b0, v); checkOutput("ovf_read3", v, 32'h104);
    readReg(1'b0, v); checkOutput("ovf_read_empty", v, 32'h000);
    writeReg(1'b1, 32'h1);
    readReg(1'b1, v); checkOutput("ovf_cleared", v, 32'h001);

    for (int i = 1; i <= 4; i++) sendFrame(8'(i), ~^(8'(i)), 1'b1, 1'b0, pop_val);
    readReg(1'b1, v); checkOutput("race_prefull", v, 32'h402);
    sendFrame(8'h05, 1'b1, 1'b1, 1'b1, pop_val);
    checkOutput("race_pop_val", pop_val, 32'h101);
    readReg(1'b1, v); checkOutput("race_status", v, 32'h402);
    for (int i = 2; i <= 5; i++) begin
      readReg(1'b0, v); checkOutput($sformatf("race_order%0d", i), v, 32'h100 | 32'(i));
    end
    readReg(1'b1, v); checkOutput("race_drained", v, 32'h001);

    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    repeat (TIMEOUT + 5) @(negedge clk);
    readReg(1'b1, v); checkOutput("timeout_status", v, 32'h009);
    writeReg(1'b1, 32'h1);
    sendFrame(8'hF0, 1'b1, 1'b1, 1'b0, pop_val);
    readReg(1'b0, v); checkOutput("after_timeout_read", v, 32'h1F0);
    readReg(1'b1, v); checkOutput("after_timeout_status", v, 32'h001);

    sendBit(1'b0);
    for (int i = 0; i < 5; i++) sendBit(1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ps2_data = 1'b1;
    readReg(1'b1, v); checkOutput("midframe_reset_status", v, 32'h001);
    sendFrame(8'h5A, 1'b1, 1'b1, 1'b0, pop_val);
    readReg(1'b0, v); checkOutput("midframe_next_read", v, 32'h15A);

    m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    mq.delete();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic p, s;
      int reads;
      d = 8'($urandom);
      p = ~^d;
      if ($urandom_range(0, 4) == 0) p = ~p;
      s = ($urandom_range(0, 7) != 0);
      sendFrame(d, p, s, 1'b0, pop_val);
      modelFrame(d, p, s);
      readReg(1'b1, v); checkOutput($sformatf("rand%0d_status", n), v, modelStatus());
      reads = $urandom_range(0, 2);
      for (int r = 0; r < reads; r++) begin
        logic [31:0] exp;
        exp = (mq.size() == 0) ? 32'h0 : (32'h100 | 32'(mq.pop_front()));
        readReg(1'b0, v); checkOutput($sformatf("rand%0d_read%0d", n, r), v, exp);
      end
      if ($urandom_range(0, 3) == 0) begin
        writeReg(1'b1, 32'h1);
        m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
        readReg(1'b1, v); checkOutput($sformatf("rand%0d_clear", n), v, modelStatus());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
